// File: rtl/pool_out_fifo_if.sv
// Pixel stream bundle between the max-pool stage, the output FIFO and the next layer.
// Master side drives the write strobe/data and the read request.
// Slave side (the FIFO) returns read data, status flags and frame markers.
interface pool_out_fifo_if #(
  parameter int Datawidth = 16,
  parameter int Addr_W    = 4
);
  logic [Datawidth-1:0] In;
  logic                 Valid_IN;
  logic                 Rd_EN;
  logic [Datawidth-1:0] Out;
  logic                 Valid_OUT;
  logic                 Full;
  logic                 Empty;
  logic [Addr_W:0]      Count;
  logic                 Frame_Done;
  logic                 Overflow;

  modport master (
    output In, Valid_IN, Rd_EN,
    input  Out, Valid_OUT, Full, Empty, Count, Frame_Done, Overflow
  );

  modport slave (
    input  In, Valid_IN, Rd_EN,
    output Out, Valid_OUT, Full, Empty, Count, Frame_Done, Overflow
  );
endinterface

// File: rtl/pool_out_fifo.sv
// Collects pooled pixels into a FIFO, releases them on Rd_EN and flags frame completion.
// Read latency 1 cycle (Out/Valid_OUT registered); Frame_Done one cycle after the last write.
// No input backpressure: writes arriving while full are dropped and latch Overflow.
module pool_out_fifo #(
  parameter int Datawidth  = 16,
  parameter int Depth      = 16,
  parameter int Addr_W     = 4,
  parameter int Frame_Size = 4
) (
  input logic           CLK,
  input logic           CLR,
  pool_out_fifo_if.slave bus
);

  localparam logic [Addr_W:0] FULL_CNT = (Addr_W+1)'(Depth);
  localparam int              FC_W     = (Frame_Size > 1) ? $clog2(Frame_Size) : 1;
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(Frame_Size - 1);

  logic [Datawidth-1:0] mem [Depth];
  logic [Addr_W-1:0]    wptr, rptr;
  logic [Addr_W:0]      cnt, cnt_nxt;
  logic                 full_q, empty_q, ovf_q, fd_q, vld_q;
  logic [Datawidth-1:0] out_q;
  logic [FC_W-1:0]      fcnt;
  logic                 wr_ok, rd_ok;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a concurrent write.
  assign rd_ok = bus.Rd_EN & ~empty_q;
  assign wr_ok = bus.Valid_IN & (~full_q | rd_ok);

  // Next occupancy; drives the registered Full/Empty so they track Count exactly.
  always_comb begin
    cnt_nxt = cnt;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  // Storage array; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wptr] <= bus.In;
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      cnt     <= cnt_nxt;
      full_q  <= (cnt_nxt == FULL_CNT);
      empty_q <= (cnt_nxt == '0);
      if (bus.Valid_IN & ~wr_ok) ovf_q <= 1'b1;
    end
  end

  // Registered read port: Out holds its last value between reads.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= rd_ok;
      if (rd_ok) out_q <= mem[rptr];
    end
  end

  // Frame counter advances on every strobe, dropped or not, to stay aligned with the pool stage.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      fcnt <= '0;
      fd_q <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (bus.Valid_IN) begin
        if (fcnt == FC_LAST) begin
          fcnt <= '0;
          fd_q <= 1'b1;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  assign bus.Out        = out_q;
  assign bus.Valid_OUT  = vld_q;
  assign bus.Full       = full_q;
  assign bus.Empty      = empty_q;
  assign bus.Count      = cnt;
  assign bus.Frame_Done = fd_q;
  assign bus.Overflow   = ovf_q;

endmodule
